// File: rtl/md5_range_counter_if.sv
// Handshake/bus bundle for md5_range_counter.
// Directions are named from the counter's side: _i into the counter, _o out of it.
interface md5_range_counter_if #(
  parameter int WIDTH = 32,
  parameter int LANES = 4
);
  logic                   clear_i;
  logic                   load_i;
  logic [WIDTH-1:0]       start_value_i;
  logic [WIDTH-1:0]       end_value_i;
  logic                   enable_i;
  logic                   step_i;
  logic                   ready_i;
  logic [LANES*WIDTH-1:0] counter_out_o;
  logic [LANES-1:0]       lane_valid_o;
  logic                   out_valid_o;
  logic                   running_o;
  logic                   done_o;
  logic                   error_o;

  // Controller / downstream side
  modport master (
    output clear_i, load_i, start_value_i, end_value_i, enable_i, step_i, ready_i,
    input  counter_out_o, lane_valid_o, out_valid_o, running_o, done_o, error_o
  );

  // Counter side
  modport slave (
    input  clear_i, load_i, start_value_i, end_value_i, enable_i, step_i, ready_i,
    output counter_out_o, lane_valid_o, out_valid_o, running_o, done_o, error_o
  );
endinterface

// File: rtl/md5_range_counter.sv
// Candidate-range generator: issues LANES consecutive values per accepted
// batch over an inclusive [start, end] range, with run/step/pause control,
// backpressure, partial-last-batch masking and wrap-free termination.
module md5_range_counter #(
  parameter int WIDTH = 32,
  parameter int LANES = 4
) (
  input logic                clk,
  input logic                rst,
  md5_range_counter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ARMED, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] base_q, base_d;
  logic [WIDTH-1:0] end_q, end_d;
  logic             error_q, error_d;

  logic out_valid;
  logic fire;
  logic last_batch;
  logic load_ok;

  // Compare in WIDTH+1 bits so an end value of all-ones never wraps.
  assign last_batch = ({1'b0, base_q} + (WIDTH+1)'(LANES)) > {1'b0, end_q};
  assign load_ok    = bus.start_value_i <= bus.end_value_i;
  assign fire       = out_valid & bus.ready_i;

  // A batch is presented while running, or for a single step request in ARMED.
  always_comb begin
    out_valid = 1'b0;
    case (state_q)
      RUN:     out_valid = 1'b1;
      ARMED:   out_valid = bus.step_i & ~bus.enable_i;
      default: out_valid = 1'b0;
    endcase
  end

  // Next-state logic; priority is clear, load, enable, step.
  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    end_d   = end_q;
    error_d = error_q;
    if (bus.clear_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (bus.load_i) begin
            if (load_ok) begin
              base_d  = bus.start_value_i;
              end_d   = bus.end_value_i;
              error_d = 1'b0;
              state_d = ARMED;
            end else begin
              error_d = 1'b1;
            end
          end
        end
        ARMED: begin
          if (bus.enable_i) begin
            state_d = RUN;
          end else if (fire) begin
            if (last_batch) state_d = DONE;
            else            base_d  = base_q + WIDTH'(LANES);
          end
        end
        RUN: begin
          // A batch accepted on the pausing cycle still advances base.
          if (fire && last_batch) begin
            state_d = DONE;
          end else begin
            if (fire) base_d = base_q + WIDTH'(LANES);
            if (!bus.enable_i) state_d = ARMED;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and range registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      base_q  <= '0;
      end_q   <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      end_q   <= end_d;
      error_q <= error_d;
    end
  end

  // Per-lane value and in-range mask; both are zero while IDLE.
  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    assign bus.counter_out_o[gi*WIDTH +: WIDTH] =
      (state_q == IDLE) ? '0 : base_q + WIDTH'(gi);
    assign bus.lane_valid_o[gi] = (state_q != IDLE) &&
      (({1'b0, base_q} + (WIDTH+1)'(gi)) <= {1'b0, end_q});
  end

  assign bus.out_valid_o = out_valid;
  assign bus.running_o   = (state_q == RUN);
  assign bus.done_o      = (state_q == DONE);
  assign bus.error_o     = error_q;

endmodule

// File: tb/tb_md5_range_counter.sv
// Testbench for md5_range_counter: table-driven cycle vectors on a 32-bit
// instance with a batch scoreboard, plus hand-written backpressure, async
// reset and 8-bit all-ones termination sequences.
module tb_md5_range_counter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  md5_range_counter_if #(.WIDTH(32), .LANES(4)) bus32 ();
  md5_range_counter_if #(.WIDTH(8),  .LANES(4)) bus8 ();

  md5_range_counter #(.WIDTH(32), .LANES(4)) dut32 (.clk(clk), .rst(rst), .bus(bus32.slave));
  md5_range_counter #(.WIDTH(8),  .LANES(4)) dut8  (.clk(clk), .rst(rst), .bus(bus8.slave));

  typedef struct {
    logic        clr, ld;
    logic [31:0] sv, ev;
    logic        en, st, rdy;
    logic        ov, run, dn, err;
    logic [31:0] c0;
    logic [3:0]  lv;
  } vec_t;

  typedef struct {
    logic [31:0] base;
    logic [3:0]  lv;
  } sb_t;

  int   checks = 0;
  int   errors = 0;
  sb_t  sbq[$];
  vec_t tbl[$];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic clr, input logic ld, input logic [31:0] sv,
                              input logic [31:0] ev, input logic en, input logic st,
                              input logic rdy, input logic ov, input logic run,
                              input logic dn, input logic err, input logic [31:0] c0,
                              input logic [3:0] lv);
    vec_t v;
    v.clr = clr; v.ld = ld; v.sv = sv; v.ev = ev; v.en = en; v.st = st; v.rdy = rdy;
    v.ov = ov; v.run = run; v.dn = dn; v.err = err; v.c0 = c0; v.lv = lv;
    return v;
  endfunction

  // One cycle on the 32-bit instance: drive after the edge, check mid-cycle.
  task automatic apply(input vec_t v, input string tag);
    sb_t e;
    @(posedge clk);
    #1;
    bus32.clear_i       = v.clr;
    bus32.load_i        = v.ld;
    bus32.start_value_i = v.sv;
    bus32.end_value_i   = v.ev;
    bus32.enable_i      = v.en;
    bus32.step_i        = v.st;
    bus32.ready_i       = v.rdy;
    if (v.ov && v.rdy) begin
      e.base = v.c0;
      e.lv   = v.lv;
      sbq.push_back(e);
    end
    #3;
    chk({tag, ".out_valid"},  bus32.out_valid_o, v.ov);
    chk({tag, ".running"},    bus32.running_o, v.run);
    chk({tag, ".done"},       bus32.done_o, v.dn);
    chk({tag, ".error"},      bus32.error_o, v.err);
    chk({tag, ".lane0"},      bus32.counter_out_o[31:0], v.c0);
    chk({tag, ".lane_valid"}, bus32.lane_valid_o, v.lv);
  endtask

  // One cycle on the 8-bit instance; checks the whole counter_out bus.
  task automatic apply8(input logic ld, input logic [7:0] sv, input logic [7:0] ev,
                        input logic en, input logic rdy, input logic ov, input logic dn,
                        input logic [31:0] cexp, input logic [3:0] lv, input string tag);
    @(posedge clk);
    #1;
    bus8.load_i        = ld;
    bus8.start_value_i = sv;
    bus8.end_value_i   = ev;
    bus8.enable_i      = en;
    bus8.ready_i       = rdy;
    #3;
    chk({tag, ".out_valid"},  bus8.out_valid_o, ov);
    chk({tag, ".done"},       bus8.done_o, dn);
    chk({tag, ".counter"},    bus8.counter_out_o, cexp);
    chk({tag, ".lane_valid"}, bus8.lane_valid_o, lv);
  endtask

  // Scoreboard: every accepted 32-bit batch must match the next expected one.
  sb_t          mon_e;
  logic [127:0] mon_ec;
  always @(negedge clk) begin
    if (bus32.out_valid_o === 1'b1 && bus32.ready_i === 1'b1) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb.unexpected actual=%0h required=none", bus32.counter_out_o);
      end else begin
        mon_e = sbq.pop_front();
        for (int i = 0; i < 4; i++) mon_ec[i*32 +: 32] = mon_e.base + 32'(i);
        $display("batch base=%0d lane_valid=%b", bus32.counter_out_o[31:0], bus32.lane_valid_o);
        chk("sb.counter", bus32.counter_out_o, mon_ec);
        chk("sb.lane_valid", bus32.lane_valid_o, mon_e.lv);
      end
    end
  end

  initial begin
    bus32.clear_i = 0; bus32.load_i = 0; bus32.start_value_i = 0; bus32.end_value_i = 0;
    bus32.enable_i = 0; bus32.step_i = 0; bus32.ready_i = 0;
    bus8.clear_i = 0; bus8.load_i = 0; bus8.start_value_i = 0; bus8.end_value_i = 0;
    bus8.enable_i = 0; bus8.step_i = 0; bus8.ready_i = 0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;

    //               clr ld sv  ev  en st rdy ov run dn err c0  lv
    tbl.push_back(mk(0, 0, 0,  0,  0, 0, 0,  0, 0,  0, 0,  0,  4'b0000)); // reset state
    tbl.push_back(mk(0, 1, 10, 21, 0, 0, 0,  0, 0,  0, 0,  0,  4'b0000)); // load
    tbl.push_back(mk(0, 0, 0,  0,  1, 0, 1,  0, 0,  0, 0,  10, 4'b1111)); // ARMED, enable
    tbl.push_back(mk(0, 0, 0,  0,  1, 0, 1,  1, 1,  0, 0,  10, 4'b1111));
    tbl.push_back(mk(0, 0, 0,  0,  1, 0, 1,  1, 1,  0, 0,  14, 4'b1111));
    tbl.push_back(mk(0, 0, 0,  0,  1, 0, 1,  1, 1,  0, 0,  18, 4'b1111)); // last fire
    tbl.push_back(mk(0, 0, 0,  0,  1, 0, 1,  0, 0,  1, 0,  18, 4'b1111)); // DONE
    tbl.push_back(mk(1, 0, 0,  0,  0, 0, 0,  0, 0,  1, 0,  18, 4'b1111)); // clear
    tbl.push_back(mk(0, 1, 5,  4,  0, 0, 0,  0, 0,  0, 0,  0,  4'b0000)); // bad load
    tbl.push_back(mk(0, 0, 0,  0,  0, 0, 0,  0, 0,  0, 1,  0,  4'b0000));
    tbl.push_back(mk(0, 0, 0,  0,  1, 1, 1,  0, 0,  0, 1,  0,  4'b0000)); // IDLE ignores
    tbl.push_back(mk(0, 1, 10, 19, 0, 0, 1,  0, 0,  0, 1,  0,  4'b0000)); // good load
    tbl.push_back(mk(0, 0, 0,  0,  0, 0, 1,  0, 0,  0, 0,  10, 4'b1111)); // ARMED
    tbl.push_back(mk(0, 0, 0,  0,  0, 1, 1,  1, 0,  0, 0,  10, 4'b1111)); // step
    tbl.push_back(mk(0, 0, 0,  0,  0, 0, 1,  0, 0,  0, 0,  14, 4'b1111));
    tbl.push_back(mk(0, 0, 0,  0,  0, 1, 1,  1, 0,  0, 0,  14, 4'b1111)); // step
    tbl.push_back(mk(0, 0, 0,  0,  0, 1, 0,  1, 0,  0, 0,  18, 4'b0011)); // step lost
    tbl.push_back(mk(0, 0, 0,  0,  0, 0, 1,  0, 0,  0, 0,  18, 4'b0011));
    tbl.push_back(mk(0, 0, 0,  0,  0, 1, 1,  1, 0,  0, 0,  18, 4'b0011)); // partial last
    tbl.push_back(mk(0, 0, 0,  0,  1, 1, 1,  0, 0,  1, 0,  18, 4'b0011)); // DONE frozen
    tbl.push_back(mk(0, 1, 10, 21, 0, 0, 1,  0, 0,  1, 0,  18, 4'b0011)); // re-arm
    tbl.push_back(mk(0, 0, 0,  0,  1, 1, 1,  0, 0,  0, 0,  10, 4'b1111)); // enable beats step
    tbl.push_back(mk(0, 0, 0,  0,  1, 0, 0,  1, 1,  0, 0,  10, 4'b1111)); // held
    tbl.push_back(mk(0, 1, 100, 200, 1, 0, 1, 1, 1, 0, 0,  10, 4'b1111)); // load ignored
    tbl.push_back(mk(0, 0, 0,  0,  0, 0, 0,  1, 1,  0, 0,  14, 4'b1111)); // pause
    tbl.push_back(mk(0, 0, 0,  0,  0, 0, 0,  0, 0,  0, 0,  14, 4'b1111)); // ARMED, held
    foreach (tbl[i]) apply(tbl[i], $sformatf("row%0d", i));

    // Resume with ready low for five cycles: batch must stay put.
    apply(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 14, 4'b1111), "bp.resume");
    for (int i = 0; i < 5; i++)
      apply(mk(0, 0, 0, 0, 1, 0, 0, 1, 1, 0, 0, 14, 4'b1111), $sformatf("bp%0d", i));

    // Asynchronous reset mid-RUN: outputs clear before any edge.
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst.counter",    bus32.counter_out_o, 128'd0);
    chk("rst.lane_valid", bus32.lane_valid_o, 4'd0);
    chk("rst.out_valid",  bus32.out_valid_o, 1'b0);
    chk("rst.running",    bus32.running_o, 1'b0);
    chk("rst.done",       bus32.done_o, 1'b0);
    chk("rst.error",      bus32.error_o, 1'b0);
    @(posedge clk);
    #2 rst = 1'b0;

    apply(mk(0, 0, 0,  0,  1, 0, 1, 0, 0, 0, 0, 0,  4'b0000), "post.en0");
    apply(mk(0, 0, 0,  0,  1, 0, 1, 0, 0, 0, 0, 0,  4'b0000), "post.en1");
    apply(mk(0, 1, 10, 21, 0, 0, 1, 0, 0, 0, 0, 0,  4'b0000), "post.load");
    apply(mk(0, 0, 0,  0,  1, 0, 1, 0, 0, 0, 0, 10, 4'b1111), "post.armed");
    apply(mk(0, 0, 0,  0,  1, 0, 1, 1, 1, 0, 0, 10, 4'b1111), "post.b0");
    apply(mk(0, 0, 0,  0,  1, 0, 1, 1, 1, 0, 0, 14, 4'b1111), "post.b1");
    apply(mk(0, 0, 0,  0,  1, 0, 1, 1, 1, 0, 0, 18, 4'b1111), "post.b2");
    apply(mk(0, 0, 0,  0,  1, 0, 1, 0, 0, 1, 0, 18, 4'b1111), "post.done");

    // 8-bit instance ending at all-ones: must terminate without wrapping.
    apply8(1, 8'hF8, 8'hFF, 0, 0, 0, 0, 32'h0,         4'b0000, "w8.load");
    apply8(0, 8'h00, 8'h00, 1, 1, 0, 0, 32'hFBFAF9F8,  4'b1111, "w8.armed");
    apply8(0, 8'h00, 8'h00, 1, 1, 1, 0, 32'hFBFAF9F8,  4'b1111, "w8.b0");
    apply8(0, 8'h00, 8'h00, 1, 1, 1, 0, 32'hFFFEFDFC,  4'b1111, "w8.b1");
    apply8(0, 8'h00, 8'h00, 1, 1, 0, 1, 32'hFFFEFDFC,  4'b1111, "w8.done");
    apply8(0, 8'h00, 8'h00, 1, 1, 0, 1, 32'hFFFEFDFC,  4'b1111, "w8.hold");

    @(posedge clk);
    #4;
    chk("sb.drained", 128'(sbq.size()), 128'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
